// File: rtl/linebuf_reader_pkg.sv
// rtl/linebuf_reader_pkg.sv - shared types, defaults and pixel helpers for the line buffer reader
package linebuf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2
    } state_t;

    localparam int RD_LATENCY_DEFAULT = 2;

    // Address width of the line buffer RAM shared with the write path
    localparam int RAM_WIDTH_DEFAULT = 19;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    function automatic pixel_t unpack_pixel(input logic [23:0] word);
        return pixel_t'(word);
    endfunction

    function automatic logic [23:0] pack_pixel(input pixel_t px);
        return {px.red, px.green, px.blue};
    endfunction

endpackage

// File: rtl/linebuf_reader_sig_delay.sv
// rtl/linebuf_reader_sig_delay.sv - synchronous-reset shift register for control flag alignment
module sig_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift the flags one stage per clock; reset flushes every stage
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/linebuf_reader.sv
// rtl/linebuf_reader.sv - frame/line timing, RAM read sweep and pixel alignment for the line buffer
module linebuf_reader
    import linebuf_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 858,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
    parameter int RAM_WIDTH  = RAM_WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 starttrigger,
    output logic [RAM_WIDTH-1:0] rdaddr,
    input  logic [23:0]          rddata,
    output logic [7:0]           out_red,
    output logic [7:0]           out_green,
    output logic [7:0]           out_blue,
    output logic                 out_de,
    output logic                 out_hstart,
    output logic                 out_vstart,
    output logic                 busy,
    output logic                 retrigger
);

    // Counter widths leave room for the terminal counts so comparisons never truncate
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    state_t               state;
    logic [HW-1:0]        hcnt;
    logic [VW-1:0]        vcnt;
    logic [RAM_WIDTH-1:0] addr;

    logic       rd;
    logic       line_start;
    logic       frame_start;
    logic [2:0] flags_dly;
    pixel_t     px_q;

    // Reads happen only on active lines; vertical blank lines walk the timing without touching RAM
    assign rd          = (state == ACTIVE) && (vcnt < V_ACT);
    assign line_start  = rd && (hcnt == '0);
    assign frame_start = line_start && (vcnt == '0);

    assign rdaddr = addr;

    // Frame sequencer: trigger acceptance, h/v counting and address sweep
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            addr      <= '0;
            busy      <= 1'b0;
            retrigger <= 1'b0;
        end else begin
            retrigger <= starttrigger && busy;
            case (state)
                IDLE: begin
                    if (starttrigger) begin
                        state <= ACTIVE;
                        hcnt  <= '0;
                        vcnt  <= '0;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (rd) begin
                        addr <= addr + RAM_WIDTH'(1);
                    end
                    hcnt <= hcnt + HW'(1);
                    if (hcnt == H_ACT_LAST) begin
                        state <= HBLANK;
                    end
                end
                HBLANK: begin
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        if (vcnt == V_LAST) begin
                            vcnt  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            vcnt  <= vcnt + VW'(1);
                            state <= ACTIVE;
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Delay the read strobe and markers until the RAM data for that address arrives
    sig_delay #(
        .DEPTH (RD_LATENCY),
        .WIDTH (3)
    ) u_flag_delay (
        .clock (clock),
        .reset (reset),
        .din   ({rd, line_start, frame_start}),
        .dout  (flags_dly)
    );

    // Final alignment stage: capture RAM data with its markers, blank the pixel outside reads
    always_ff @(posedge clock) begin
        if (reset) begin
            px_q       <= '0;
            out_de     <= 1'b0;
            out_hstart <= 1'b0;
            out_vstart <= 1'b0;
        end else begin
            out_de     <= flags_dly[2];
            out_hstart <= flags_dly[1];
            out_vstart <= flags_dly[0];
            px_q       <= flags_dly[2] ? unpack_pixel(rddata) : '0;
        end
    end

    assign out_red   = px_q.red;
    assign out_green = px_q.green;
    assign out_blue  = px_q.blue;

endmodule

// File: tb/tb_linebuf_reader.sv
// tb/tb_linebuf_reader.sv - scoreboard bench for linebuf_reader against a frame-level reference model
module tb_linebuf_reader;

    localparam int HA    = 6;
    localparam int HT    = 9;
    localparam int VA    = 2;
    localparam int VT    = 3;
    localparam int RW    = 3;
    localparam int RDL   = 2;
    localparam int FRAME = VT * HT;

    logic          clock;
    logic          reset;
    logic          starttrigger;
    logic [RW-1:0] rdaddr;
    logic [23:0]   rddata;
    logic [7:0]    out_red;
    logic [7:0]    out_green;
    logic [7:0]    out_blue;
    logic          out_de;
    logic          out_hstart;
    logic          out_vstart;
    logic          busy;
    logic          retrigger;

    linebuf_reader #(
        .H_ACTIVE   (HA),
        .H_TOTAL    (HT),
        .V_ACTIVE   (VA),
        .V_TOTAL    (VT),
        .RD_LATENCY (RDL),
        .RAM_WIDTH  (RW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .starttrigger (starttrigger),
        .rdaddr       (rdaddr),
        .rddata       (rddata),
        .out_red      (out_red),
        .out_green    (out_green),
        .out_blue     (out_blue),
        .out_de       (out_de),
        .out_hstart   (out_hstart),
        .out_vstart   (out_vstart),
        .busy         (busy),
        .retrigger    (retrigger)
    );

    typedef struct {
        int          cyc;
        logic [23:0] data;
        bit          hs;
        bit          vs;
    } px_t;

    typedef struct {
        bit          busy;
        bit          retrig;
        logic [RW-1:0] addr;
    } st_t;

    px_t pxq[$];
    st_t stq[$];

    logic [23:0] mem [1 << RW];
    logic [23:0] pipe [RDL];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 0;

    int            fstart = -1;
    logic [RW-1:0] idle_addr = '0;
    bit            retrig_next = 0;

    st_t ms;
    px_t mp;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read with RDL clocks from address to data
    always @(posedge clock) begin
        pipe[0] <= mem[rdaddr];
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
    end
    assign rddata = pipe[RDL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Address the read port shows at a given offset into a frame
    function automatic logic [RW-1:0] exp_addr(input int off);
        int n, k, a;
        n = off / HT;
        k = off % HT;
        if (n < VA) a = n * HA + ((k < HA) ? k : HA);
        else a = VA * HA;
        return RW'(a);
    endfunction

    task automatic push_frame(input int t);
        px_t p;
        for (int n = 0; n < VA; n++) begin
            for (int k = 0; k < HA; k++) begin
                p.cyc  = t + 2 + RDL + n * HT + k;
                p.data = mem[(n * HA + k) % (1 << RW)];
                p.hs   = (k == 0);
                p.vs   = (n == 0) && (k == 0);
                pxq.push_back(p);
            end
        end
    endtask

    task automatic tick(input bit trig, input bit rst);
        int  c;
        bit  bsy;
        st_t s;
        c = cyc;
        if (fstart >= 0 && c > fstart + FRAME) begin
            fstart    = -1;
            idle_addr = RW'(VA * HA);
        end
        bsy      = (fstart >= 0) && (c > fstart);
        s.busy   = bsy;
        s.retrig = retrig_next;
        s.addr   = bsy ? exp_addr(c - fstart - 1) : idle_addr;
        stq.push_back(s);
        starttrigger = trig;
        reset        = rst;
        if (rst) begin
            fstart      = -1;
            idle_addr   = '0;
            retrig_next = 0;
            while (pxq.size() > 0 && pxq[pxq.size()-1].cyc > c) pxq.delete(pxq.size() - 1);
        end else begin
            retrig_next = trig && bsy;
            if (trig && !bsy) begin
                fstart = c;
                push_frame(c);
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare status every cycle and pop the pixel scoreboard when a pixel is due
    always @(negedge clock) begin
        if (mon_on) begin
            if (stq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL status_queue cycle=%0d got=empty expected=entry", cyc);
            end else begin
                ms = stq.pop_front();
                chk("busy", 32'(busy), 32'(ms.busy));
                chk("retrigger", 32'(retrigger), 32'(ms.retrig));
                chk("rdaddr", 32'(rdaddr), 32'(ms.addr));
            end
            while (pxq.size() > 0 && pxq[0].cyc < cyc) begin
                mp = pxq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_pixel cycle=%0d got=none expected=%0h", mp.cyc, mp.data);
            end
            if (pxq.size() > 0 && pxq[0].cyc == cyc) begin
                mp = pxq.pop_front();
                chk("out_de", 32'(out_de), 32'd1);
                chk("pixel", 32'({out_red, out_green, out_blue}), 32'(mp.data));
                chk("out_hstart", 32'(out_hstart), 32'(mp.hs));
                chk("out_vstart", 32'(out_vstart), 32'(mp.vs));
            end else begin
                chk("out_de_idle", 32'(out_de), 32'd0);
                chk("pixel_idle", 32'({out_red, out_green, out_blue}), 32'd0);
                chk("out_hstart_idle", 32'(out_hstart), 32'd0);
                chk("out_vstart_idle", 32'(out_vstart), 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << RW); i++) mem[i] = 24'($urandom);
        reset        = 1'b1;
        starttrigger = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        mon_on = 1;

        repeat (3) tick(0, 0);
        // single frame, then idle
        tick(1, 0);
        repeat (FRAME + 3) tick(0, 0);
        // trigger while busy at T+5
        tick(1, 0);
        repeat (4) tick(0, 0);
        tick(1, 0);
        repeat (FRAME) tick(0, 0);
        // reset in the middle of the first active line at T+6
        tick(1, 0);
        repeat (5) tick(0, 0);
        tick(0, 1);
        repeat (3) tick(0, 0);
        // back-to-back frames: retrigger on the first idle cycle
        tick(1, 0);
        repeat (FRAME) tick(0, 0);
        tick(1, 0);
        repeat (FRAME + 5) tick(0, 0);
        // random triggers and occasional resets
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        repeat (FRAME + 10) tick(0, 0);

        mon_on = 0;
        total++;
        if (pxq.size() != 0) begin
            bad++;
            $display("FAIL leftover_pixels got=%0d expected=0", pxq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
